// File: rtl/mul_ctrl.sv
// Sequencer around an external sign-magnitude multiplier: launches it, waits for the product, loads rA/rX.
// Optional build macro MUL_SKIP_ZERO_EN short-circuits zero operands straight to a signed-zero result.

// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for req; operands captured on acceptance
// S_LAUNCH | mul_start high for this single cycle
// S_FEED   | multiplier samples mul_in2 this cycle
// S_WAIT   | waiting for mul_stop, down-counter guards against a hang
// S_DONE   | done high for this single cycle
module mul_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [30:0] opa,
    input  logic [30:0] opb,
    output logic        mul_start,
    output logic [30:0] mul_in1,
    output logic [30:0] mul_in2,
    input  logic [59:0] mul_out,
    input  logic        mul_stop,
    input  logic        mul_sign,
    output logic [30:0] ra,
    output logic [30:0] rx,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_FEED,
        S_WAIT,
        S_DONE
    } state_t;

    // Loaded on WAIT entry; terminal count 0 is reached on the 12th WAIT cycle.
    localparam logic [3:0] WAIT_LOAD = 4'd11;

    state_t      state;
    logic [30:0] opa_q;
    logic [30:0] opb_q;
    logic [3:0]  wait_cnt;
    logic        zero_op;

`ifdef MUL_SKIP_ZERO_EN
    assign zero_op = (opa[29:0] == 30'd0) || (opb[29:0] == 30'd0);
`else
    assign zero_op = 1'b0;
`endif

    assign mul_in1 = opa_q;
    assign mul_in2 = opb_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            opa_q     <= '0;
            opb_q     <= '0;
            wait_cnt  <= '0;
            mul_start <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            ra        <= '0;
            rx        <= '0;
        end else begin
            mul_start <= 1'b0;
            done      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        opa_q <= opa;
                        opb_q <= opb;
                        err   <= 1'b0;
                        busy  <= 1'b1;
                        if (zero_op) begin
                            ra    <= {opa[30] ^ opb[30], 30'd0};
                            rx    <= {opa[30] ^ opb[30], 30'd0};
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            mul_start <= 1'b1;
                            state     <= S_LAUNCH;
                        end
                    end
                end
                S_LAUNCH: begin
                    state <= S_FEED;
                end
                S_FEED: begin
                    wait_cnt <= WAIT_LOAD;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    // A product arriving on the timeout cycle still counts as success.
                    if (mul_stop) begin
                        ra    <= {mul_sign, mul_out[59:30]};
                        rx    <= {mul_sign, mul_out[29:0]};
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else if (wait_cnt == 4'd0) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_ctrl.sv
// Directed bench for mul_ctrl with a behavioural multiplier answering 9 cycles after mul_start.
// Zero-operand expectations follow MUL_SKIP_ZERO_EN when the bench is built with it.
module tb_mul_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic [30:0] opa = '0;
    logic [30:0] opb = '0;
    logic        mul_start;
    logic [30:0] mul_in1;
    logic [30:0] mul_in2;
    logic [59:0] mul_out;
    logic        mul_stop;
    logic        mul_sign;
    logic [30:0] ra;
    logic [30:0] rx;
    logic        busy;
    logic        done;
    logic        err;

    int pass_cnt = 0;
    int chk_cnt = 0;

    mul_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .opa       (opa),
        .opb       (opb),
        .mul_start (mul_start),
        .mul_in1   (mul_in1),
        .mul_in2   (mul_in2),
        .mul_out   (mul_out),
        .mul_stop  (mul_stop),
        .mul_sign  (mul_sign),
        .ra        (ra),
        .rx        (rx),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Multiplier model: in1 taken with start, in2 one cycle later, stop pulse in the 9th cycle after start.
    logic [30:0] m_in1 = '0;
    logic [3:0]  m_cnt = '0;
    logic [59:0] m_prod = '0;
    logic        m_sgn = 1'b0;
    logic        model_stop = 1'b0;
    logic        model_en = 1'b1;
    logic        stray_stop = 1'b0;

    always @(posedge clk) begin
        model_stop <= 1'b0;
        if (mul_start) begin
            m_in1 <= mul_in1;
            m_cnt <= 4'd8;
        end else if (m_cnt != 4'd0) begin
            if (m_cnt == 4'd8) begin
                m_prod <= {30'd0, m_in1[29:0]} * {30'd0, mul_in2[29:0]};
                m_sgn  <= m_in1[30] ^ mul_in2[30];
            end
            if (m_cnt == 4'd1 && model_en) model_stop <= 1'b1;
            m_cnt <= m_cnt - 4'd1;
        end
    end

    assign mul_out  = m_prod;
    assign mul_sign = m_sgn;
    assign mul_stop = model_stop | stray_stop;

    // Issues one req in cycle T and watches cycles T+1..T+20; optional stray stop / repeated req at a given cycle.
    task automatic run_op(input logic [30:0] a, input logic [30:0] b, input int stop_at, input int req_at,
                          output int start_cyc, output int done_cyc, output int nstart, output int ndone,
                          output logic err1);
        start_cyc = -1;
        done_cyc  = -1;
        nstart    = 0;
        ndone     = 0;
        err1      = 1'bx;
        opa = a;
        opb = b;
        req = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 20; k++) begin
            req        = (k == req_at);
            stray_stop = (k == stop_at);
            @(negedge clk);
            if (k == 1) err1 = err;
            if (mul_start) begin
                nstart++;
                if (start_cyc < 0) start_cyc = k;
            end
            if (done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = k;
            end
            @(posedge clk); #1;
        end
        req        = 1'b0;
        stray_stop = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        chk_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else pass_cnt++;
        chk_cnt++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else pass_cnt++;
        chk_cnt++; if (mul_start !== 1'b0) $display("FAIL reset_start: got %b want 0", mul_start); else pass_cnt++;
        chk_cnt++; if (ra !== 31'h0) $display("FAIL reset_ra: got %h want 0", ra); else pass_cnt++;
        chk_cnt++; if (rx !== 31'h0) $display("FAIL reset_rx: got %h want 0", rx); else pass_cnt++;
        chk_cnt++; if (mul_in1 !== 31'h0) $display("FAIL reset_in1: got %h want 0", mul_in1); else pass_cnt++;
        chk_cnt++; if (mul_in2 !== 31'h0) $display("FAIL reset_in2: got %h want 0", mul_in2); else pass_cnt++;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int s, d, ns, nd;
        logic e1;
        run_op(31'd2, 31'h40000003, 0, 0, s, d, ns, nd, e1);
        chk_cnt++; if (s !== 1) $display("FAIL basic_start_cyc: got %0d want 1", s); else pass_cnt++;
        chk_cnt++; if (ns !== 1) $display("FAIL basic_start_count: got %0d want 1", ns); else pass_cnt++;
        chk_cnt++; if (d !== 11) $display("FAIL basic_done_cyc: got %0d want 11", d); else pass_cnt++;
        chk_cnt++; if (nd !== 1) $display("FAIL basic_done_count: got %0d want 1", nd); else pass_cnt++;
        chk_cnt++; if (ra !== 31'h40000000) $display("FAIL basic_ra: got %h want 40000000", ra); else pass_cnt++;
        chk_cnt++; if (rx !== 31'h40000006) $display("FAIL basic_rx: got %h want 40000006", rx); else pass_cnt++;
        chk_cnt++; if (err !== 1'b0) $display("FAIL basic_err: got %b want 0", err); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL basic_busy_after: got %b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_max();
        int s, d, ns, nd;
        logic e1;
        run_op(31'h3FFFFFFF, 31'h3FFFFFFF, 0, 0, s, d, ns, nd, e1);
        chk_cnt++; if (d !== 11) $display("FAIL max_done_cyc: got %0d want 11", d); else pass_cnt++;
        chk_cnt++; if (ra !== 31'h3FFFFFFE) $display("FAIL max_ra: got %h want 3FFFFFFE", ra); else pass_cnt++;
        chk_cnt++; if (rx !== 31'h00000001) $display("FAIL max_rx: got %h want 00000001", rx); else pass_cnt++;
    endtask

    task automatic test_zero();
        int s, d, ns, nd;
        logic e1;
        int exp_d, exp_ns;
`ifdef MUL_SKIP_ZERO_EN
        exp_d  = 1;
        exp_ns = 0;
`else
        exp_d  = 11;
        exp_ns = 1;
`endif
        run_op(31'h40000000, 31'd5, 0, 0, s, d, ns, nd, e1);
        chk_cnt++; if (d !== exp_d) $display("FAIL zero_done_cyc: got %0d want %0d", d, exp_d); else pass_cnt++;
        chk_cnt++; if (ns !== exp_ns) $display("FAIL zero_start_count: got %0d want %0d", ns, exp_ns); else pass_cnt++;
        chk_cnt++; if (nd !== 1) $display("FAIL zero_done_count: got %0d want 1", nd); else pass_cnt++;
        chk_cnt++; if (ra !== 31'h40000000) $display("FAIL zero_ra: got %h want 40000000", ra); else pass_cnt++;
        chk_cnt++; if (rx !== 31'h40000000) $display("FAIL zero_rx: got %h want 40000000", rx); else pass_cnt++;
    endtask

    task automatic test_timeout();
        int s, d, ns, nd;
        logic e1;
        model_en = 1'b0;
        run_op(31'd7, 31'd9, 0, 0, s, d, ns, nd, e1);
        chk_cnt++; if (d !== 15) $display("FAIL timeout_done_cyc: got %0d want 15", d); else pass_cnt++;
        chk_cnt++; if (nd !== 1) $display("FAIL timeout_done_count: got %0d want 1", nd); else pass_cnt++;
        chk_cnt++; if (err !== 1'b1) $display("FAIL timeout_err: got %b want 1", err); else pass_cnt++;
        chk_cnt++; if (ra !== 31'h40000000) $display("FAIL timeout_ra_held: got %h want 40000000", ra); else pass_cnt++;
        chk_cnt++; if (rx !== 31'h40000000) $display("FAIL timeout_rx_held: got %h want 40000000", rx); else pass_cnt++;
    endtask

    // Stop lands on the 12th WAIT cycle: results load, err from the previous timeout clears at acceptance.
    task automatic test_stop_at_timeout();
        int s, d, ns, nd;
        logic e1;
        model_en = 1'b0;
        run_op(31'd3, 31'd5, 14, 0, s, d, ns, nd, e1);
        model_en = 1'b1;
        chk_cnt++; if (e1 !== 1'b0) $display("FAIL edge_err_cleared: got %b want 0", e1); else pass_cnt++;
        chk_cnt++; if (d !== 15) $display("FAIL edge_done_cyc: got %0d want 15", d); else pass_cnt++;
        chk_cnt++; if (err !== 1'b0) $display("FAIL edge_err: got %b want 0", err); else pass_cnt++;
        chk_cnt++; if (ra !== 31'h0) $display("FAIL edge_ra: got %h want 0", ra); else pass_cnt++;
        chk_cnt++; if (rx !== 31'd15) $display("FAIL edge_rx: got %h want f", rx); else pass_cnt++;
    endtask

    task automatic test_busy_ignore();
        int s, d, ns, nd;
        logic e1;
        run_op(31'd4, 31'd4, 0, 5, s, d, ns, nd, e1);
        chk_cnt++; if (nd !== 1) $display("FAIL busy_done_count: got %0d want 1", nd); else pass_cnt++;
        chk_cnt++; if (ns !== 1) $display("FAIL busy_start_count: got %0d want 1", ns); else pass_cnt++;
        chk_cnt++; if (rx !== 31'd16) $display("FAIL busy_rx: got %h want 10", rx); else pass_cnt++;
        stray_stop = 1'b1;
        @(negedge clk);
        chk_cnt++; if (busy !== 1'b0) $display("FAIL stray_busy: got %b want 0", busy); else pass_cnt++;
        @(posedge clk); #1;
        stray_stop = 1'b0;
        @(negedge clk);
        chk_cnt++; if (done !== 1'b0) $display("FAIL stray_done: got %b want 0", done); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL stray_busy_after: got %b want 0", busy); else pass_cnt++;
        chk_cnt++; if (ra !== 31'h0) $display("FAIL stray_ra: got %h want 0", ra); else pass_cnt++;
        chk_cnt++; if (rx !== 31'd16) $display("FAIL stray_rx: got %h want 10", rx); else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int s, d, ns, nd;
        logic e1;
        opa = 31'd2;
        opb = 31'd2;
        req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk_cnt++; if (busy !== 1'b1) $display("FAIL mid_busy_before: got %b want 1", busy); else pass_cnt++;
        rst_n = 1'b0;
        #1;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", busy); else pass_cnt++;
        chk_cnt++; if (ra !== 31'h0) $display("FAIL mid_ra: got %h want 0", ra); else pass_cnt++;
        chk_cnt++; if (rx !== 31'h0) $display("FAIL mid_rx: got %h want 0", rx); else pass_cnt++;
        chk_cnt++; if (mul_in1 !== 31'h0) $display("FAIL mid_in1: got %h want 0", mul_in1); else pass_cnt++;
        chk_cnt++; if ({mul_start, done, err} !== 3'b000) $display("FAIL mid_pulses: got %b want 000", {mul_start, done, err}); else pass_cnt++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_op(31'd6, 31'h40000007, 0, 0, s, d, ns, nd, e1);
        chk_cnt++; if (d !== 11) $display("FAIL mid_done_cyc: got %0d want 11", d); else pass_cnt++;
        chk_cnt++; if (nd !== 1) $display("FAIL mid_done_count: got %0d want 1", nd); else pass_cnt++;
        chk_cnt++; if (ra !== 31'h40000000) $display("FAIL mid_new_ra: got %h want 40000000", ra); else pass_cnt++;
        chk_cnt++; if (rx !== 31'h4000002A) $display("FAIL mid_new_rx: got %h want 4000002a", rx); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_zero();
        test_timeout();
        test_stop_at_timeout();
        test_busy_ignore();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
